// File: rtl/dct_pkg.sv
// dct_pkg: shared sizes and state type for the 2-D DCT sequencing controller.
package dct_pkg;
  localparam int N       = 16;
  localparam int NUM_BLK = 32;
  localparam int ROW_LAT = 2;
  localparam int COL_LAT = 2;
  localparam int ADDR_W  = 9;
  localparam int IDX_W   = $clog2(N);
  localparam int BLK_W   = $clog2(NUM_BLK);
  typedef enum logic [2:0] {IDLE, ROW, ROW_DRAIN, COL, COL_DRAIN, DONE} state_t;
endpackage

// File: rtl/dct2d_ctrl_if.sv
// dct2d_ctrl_if: control/strobe bundle between the DCT controller and its datapath/memories.
interface dct2d_ctrl_if;
  import dct_pkg::*;
  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic              dp_ce;
  logic              in_rd_en;
  logic [ADDR_W-1:0] in_addr;
  logic              row_vld;
  logic              tb_wr_en;
  logic [IDX_W-1:0]  tb_wr_row;
  logic              tb_rd_en;
  logic [IDX_W-1:0]  tb_rd_col;
  logic              col_vld;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic [BLK_W-1:0]  blk_idx;
  modport master (
    input  start, hold,
    output busy, done, dp_ce, in_rd_en, in_addr, row_vld, tb_wr_en, tb_wr_row,
           tb_rd_en, tb_rd_col, col_vld, out_wr_en, out_addr, blk_idx
  );
  modport slave (
    output start, hold,
    input  busy, done, dp_ce, in_rd_en, in_addr, row_vld, tb_wr_en, tb_wr_row,
           tb_rd_en, tb_rd_col, col_vld, out_wr_en, out_addr, blk_idx
  );
endinterface

// File: rtl/dct_vld_pipe.sv
// dct_vld_pipe: hold-freezable shift register carrying {valid, index}; exposes first and last stage.
module dct_vld_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         d_vld,
  input  logic [W-1:0] d_idx,
  output logic         first_vld,
  output logic         last_vld,
  output logic [W-1:0] last_idx
);
  logic [W:0] sr [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (!hold) begin
      sr[0] <= {d_vld, d_idx};
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end
  assign first_vld            = sr[0][W];
  assign {last_vld, last_idx} = sr[DEPTH-1];
endmodule

// File: rtl/dct2d_ctrl.sv
// dct2d_ctrl: block-by-block sequencer for the 16-point 2-D DCT datapath.
module dct2d_ctrl
  import dct_pkg::*;
(
  input logic          clk,
  input logic          rst,
  dct2d_ctrl_if.master bus
);
  state_t           state, nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt, row_idx, col_idx;
  logic [BLK_W-1:0] blk, blk_nxt;
  logic             pend, go, row_first, row_last, col_first, col_last;
  assign go = (state == IDLE) && (bus.start || pend) && !bus.hold;
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + 1'b1;
    blk_nxt = blk;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        nxt     = go ? ROW : IDLE;
        blk_nxt = go ? '0 : blk;
      end
      ROW: begin
        nxt     = (cnt == IDX_W'(N-1)) ? ROW_DRAIN : ROW;
        cnt_nxt = (cnt == IDX_W'(N-1)) ? '0 : cnt + 1'b1;
      end
      ROW_DRAIN: begin
        nxt     = (cnt == IDX_W'(ROW_LAT)) ? COL : ROW_DRAIN;
        cnt_nxt = (cnt == IDX_W'(ROW_LAT)) ? '0 : cnt + 1'b1;
      end
      COL: begin
        nxt     = (cnt == IDX_W'(N-1)) ? COL_DRAIN : COL;
        cnt_nxt = (cnt == IDX_W'(N-1)) ? '0 : cnt + 1'b1;
      end
      COL_DRAIN: begin
        if (cnt == IDX_W'(COL_LAT)) begin
          cnt_nxt = '0;
          nxt     = (blk == BLK_W'(NUM_BLK-1)) ? DONE : ROW;
          blk_nxt = (blk == BLK_W'(NUM_BLK-1)) ? blk : blk + 1'b1;
        end
      end
      default: begin
        cnt_nxt = '0;
        nxt     = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      blk   <= '0;
      pend  <= 1'b0;
    end else begin
      // a start seen while frozen is remembered until hold releases
      pend <= (state == IDLE) && bus.hold && (bus.start || pend);
      if (!bus.hold) begin
        state <= nxt;
        cnt   <= cnt_nxt;
        blk   <= blk_nxt;
      end
    end
  end
  dct_vld_pipe #(.DEPTH(1+ROW_LAT), .W(IDX_W)) u_row_pipe (
    .clk(clk), .rst(rst), .hold(bus.hold),
    .d_vld(state == ROW), .d_idx(cnt),
    .first_vld(row_first), .last_vld(row_last), .last_idx(row_idx)
  );
  dct_vld_pipe #(.DEPTH(1+COL_LAT), .W(IDX_W)) u_col_pipe (
    .clk(clk), .rst(rst), .hold(bus.hold),
    .d_vld(state == COL), .d_idx(cnt),
    .first_vld(col_first), .last_vld(col_last), .last_idx(col_idx)
  );
  assign bus.dp_ce     = !bus.hold;
  assign bus.busy      = state inside {ROW, ROW_DRAIN, COL, COL_DRAIN};
  assign bus.done      = (state == DONE) && !bus.hold;
  assign bus.in_rd_en  = (state == ROW) && !bus.hold;
  assign bus.in_addr   = {blk, cnt};
  assign bus.row_vld   = row_first && !bus.hold;
  assign bus.tb_wr_en  = row_last && !bus.hold;
  assign bus.tb_wr_row = row_idx;
  assign bus.tb_rd_en  = (state == COL) && !bus.hold;
  assign bus.tb_rd_col = cnt;
  assign bus.col_vld   = col_first && !bus.hold;
  assign bus.out_wr_en = col_last && !bus.hold;
  assign bus.out_addr  = {blk, col_idx};
  assign bus.blk_idx   = blk;
endmodule

// File: tb/tb_dct2d_ctrl.sv
// tb_dct2d_ctrl: directed bench for dct2d_ctrl with a negedge monitor scoreboarding every strobe.
module tb_dct2d_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  dct2d_ctrl_if bus ();
  dct2d_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  int cyc, t0, rel;
  bit t0_set;
  int exp_in, exp_out, n_in, n_out, n_wr, n_rd, n_ovl, n_hold_str, n_done, n_busy;
  int first_wr_rel, first_wr_row, wr15_rel, wr15_row, rd_rel, rd_col, done_rel;
  task automatic clear_stats();
    t0_set = 0; exp_in = 0; exp_out = 0; n_in = 0; n_out = 0; n_wr = 0; n_rd = 0;
    n_ovl = 0; n_hold_str = 0; n_done = 0; n_busy = 0;
    first_wr_rel = -1; first_wr_row = -1; wr15_rel = -1; wr15_row = -1;
    rd_rel = -1; rd_col = -1; done_rel = -1;
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!t0_set && bus.busy) begin
      t0_set = 1;
      t0 = cyc;
    end
    rel = cyc - t0;
    if (bus.in_rd_en) begin
      check("in_addr", 32'(bus.in_addr), 32'(exp_in));
      exp_in++;
      n_in++;
    end
    if (bus.out_wr_en) begin
      check("out_addr", 32'(bus.out_addr), 32'(exp_out));
      check("out_blk", 32'(bus.blk_idx), 32'(exp_out / 16));
      exp_out++;
      n_out++;
    end
    if (bus.tb_wr_en && bus.tb_rd_en) n_ovl++;
    if (bus.hold && (bus.in_rd_en || bus.row_vld || bus.tb_wr_en || bus.tb_rd_en || bus.col_vld || bus.out_wr_en))
      n_hold_str++;
    if (bus.tb_wr_en) begin
      if (n_wr == 0) begin first_wr_rel = rel; first_wr_row = int'(bus.tb_wr_row); end
      if (n_wr == 15) begin wr15_rel = rel; wr15_row = int'(bus.tb_wr_row); end
      n_wr++;
    end
    if (bus.tb_rd_en) begin
      if (n_rd == 0) begin rd_rel = rel; rd_col = int'(bus.tb_rd_col); end
      n_rd++;
    end
    if (bus.done) begin
      done_rel = rel;
      n_done++;
    end
    if (bus.busy) n_busy++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    clear_stats();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 1400 && n_done == 0; i++) tick();
    check("done_seen", 32'(n_done), 32'd1);
    repeat (3) tick();
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_dp_ce"}, 32'(bus.dp_ce), 1);
    check({tag, "_in_rd_en"}, 32'(bus.in_rd_en), 0);
    check({tag, "_in_addr"}, 32'(bus.in_addr), 0);
    check({tag, "_row_vld"}, 32'(bus.row_vld), 0);
    check({tag, "_tb_wr_en"}, 32'(bus.tb_wr_en), 0);
    check({tag, "_tb_wr_row"}, 32'(bus.tb_wr_row), 0);
    check({tag, "_tb_rd_en"}, 32'(bus.tb_rd_en), 0);
    check({tag, "_tb_rd_col"}, 32'(bus.tb_rd_col), 0);
    check({tag, "_col_vld"}, 32'(bus.col_vld), 0);
    check({tag, "_out_wr_en"}, 32'(bus.out_wr_en), 0);
    check({tag, "_out_addr"}, 32'(bus.out_addr), 0);
    check({tag, "_blk_idx"}, 32'(bus.blk_idx), 0);
  endtask
  task automatic check_run(input string tag, input int exp_done, input int exp_busy);
    check({tag, "_n_in"}, 32'(n_in), 512);
    check({tag, "_n_out"}, 32'(n_out), 512);
    check({tag, "_n_wr"}, 32'(n_wr), 512);
    check({tag, "_n_rd"}, 32'(n_rd), 512);
    check({tag, "_overlap"}, 32'(n_ovl), 0);
    check({tag, "_done_rel"}, 32'(done_rel), 32'(exp_done));
    check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
  endtask
  initial begin
    cyc = 0;
    t0 = 0;
    clear_stats();
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_idle("reset");
    pulse_start();
    wait_done();
    check_run("plain", 1216, 1216);
    check("plain_first_wr_rel", 32'(first_wr_rel), 3);
    check("plain_first_wr_row", 32'(first_wr_row), 0);
    check("plain_wr15_rel", 32'(wr15_rel), 18);
    check("plain_wr15_row", 32'(wr15_row), 15);
    check("plain_rd_rel", 32'(rd_rel), 19);
    check("plain_rd_col", 32'(rd_col), 0);
    pulse_start();
    repeat (10) tick();
    bus.hold = 1'b1;
    repeat (5) tick();
    bus.hold = 1'b0;
    wait_done();
    check_run("hold", 1221, 1221);
    check("hold_strobes", 32'(n_hold_str), 0);
    check("hold_first_wr_rel", 32'(first_wr_rel), 3);
    check("hold_wr15_rel", 32'(wr15_rel), 23);
    check("hold_rd_rel", 32'(rd_rel), 24);
    pulse_start();
    repeat (100) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    check_run("restart_ignored", 1216, 1216);
    pulse_start();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midrst");
    clear_stats();
    repeat (60) tick();
    check("midrst_out_wr", 32'(n_out), 0);
    check("midrst_tb_wr", 32'(n_wr), 0);
    check("midrst_in_rd", 32'(n_in), 0);
    pulse_start();
    tick();
    check("midrst_new_in_addr", 32'(bus.in_addr), 1);
    wait_done();
    check_run("after_rst", 1216, 1216);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
